lsu_stage: RTL and testbench
============================

# lsu_stage

Load/store unit sitting directly upstream of the memory stage. Accepts one byte/half/word load or store per transaction from the execute pipeline and converts it into word-aligned word accesses on the memory stage's level-held req / pulsed fin handshake. Sub-word stores use read-modify-write; loads are lane-extracted and sign- or zero-extended. Misaligned accesses are rejected without touching memory.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  upstream transaction valid
- req_ready  out  1  high when idle; transfer on req_valid & req_ready at posedge
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  SZ_B=0, SZ_H=1, SZ_W=2; value 3 is treated as misaligned
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- done  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid with done; held until the next done
- err  out  1  valid with done: misaligned, no memory access made
- mem_rd_req / mem_wr_req  out  1  level requests to the memory stage
- mem_rd_fin / mem_wr_fin  in  1  one-cycle completion pulses from the memory stage
- mem_rd_addr / mem_wr_addr  out  32  word address, always {addr[31:2],2'b00}
- mem_wr_data  out  32  full write word
- mem_rd_data  in  32  read word, valid when mem_rd_fin is high

## Operation
- Lane mapping is little-endian: byte k of a word occupies bits [8k+7:8k], with k = addr[1:0]. A half-word uses lanes addr[1]*2 and addr[1]*2+1.
- A request is misaligned when size=H and addr[0]=1, when size=W and addr[1:0]≠0, or when size=3.
- States: IDLE, LD, RMW_RD, RMW_WR, ST, ERR.
- IDLE: req_ready=1. On accept, latch all request fields:
  - Misaligned → ERR.
  - Load → LD, with mem_rd_req←1.
  - Word store → ST, with mem_wr_req←1 and mem_wr_data←wdata.
  - B/H store → RMW_RD, with mem_rd_req←1.
- LD: on mem_rd_fin, mem_rd_req←0, rdata←extend(lane(mem_rd_data)), err←0, done←1, state→IDLE.
- RMW_RD: on mem_rd_fin, mem_rd_req←0, mem_wr_req←1, mem_wr_data←mem_rd_data with the addressed lanes replaced by wdata[7:0] or wdata[15:0], state→RMW_WR.
- RMW_WR / ST: on mem_wr_fin, mem_wr_req←0, err←0, done←1, state→IDLE.
- ERR: done←1, err←1, rdata unchanged, state→IDLE.
- mem_rd_req and mem_wr_req are never high together. Each request drops on the same edge its fin is sampled, so the memory stage never re-triggers.
- A fin pulse that does not match the outstanding request is ignored.
- reset (any time, including mid-transaction): state=IDLE; done, err, mem_rd_req and mem_wr_req all 0; rdata=0 and mem_wr_data=0. req_ready=1 after reset deasserts. The memory stage shares this reset, so no outstanding access survives it.

## Timing
- Every output is registered except req_ready (decoded from state) and the address outputs (driven from the latched address).
- Acceptance edge T0: the memory request is high from T0.
- Load: mem_rd_fin sampled high at edge Tf gives done=1 in the cycle after Tf. req_ready is also high in that cycle.
- Word store: same as a load, using the write handshake.
- Sub-word store: read fin at Tf, mem_wr_req high from Tf, write fin at Tg, done in the cycle after Tg.
- Misaligned: done and err high in the cycle after T0+1 edge, i.e. 2 cycles after acceptance; zero memory requests.
- Back-to-back: a new request may be accepted in the same cycle done is high. Its memory request then rises one cycle after the previous fin was dropped, which the memory stage's FIN→IDLE cycle absorbs.

## Structure
- Shared package `lsu_pkg` holds the SZ_B/SZ_H/SZ_W encodings and the state encoding localparams.
- One combinational sub-module, `lsu_align`, with inputs word, addr[1:0], size, unsigned and wdata. Its outputs are the extracted load value and the merged store word.
- `lsu_stage` contains the FSM and registers only.

## Test plan
- Load byte from addr 0x103, memory word 0x80FF_1234 at 0x100, signed → mem_rd_addr=0x100, rdata=0xFFFF_FF80. The same with unsigned → 0x0000_0080.
- Store half 0xBEEF to addr 0x202, memory 0x1122_3344 → one read, then one write of 0xBEEF_3344 to 0x200, done after the write fin.
- Word store to 0x300 → only mem_wr_req asserted, mem_wr_data=req_wdata, mem_rd_req stays 0.
- Word load from 0x401, and half load from 0x405 → done and err=1 two cycles after accept, no mem_*_req ever high.
- Back-to-back load then store with the memory stage model inserting 0 and 5 wait cycles → no overlapping requests, req dropped on the fin edge, exactly one done per transaction.
- Assert reset during RMW_WR → outputs return to their reset values immediately; a following load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment rule used at request acceptance.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LD     = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_RMW_WR = 3'd3;
  localparam logic [2:0] ST_ST     = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LD     = ST_LD,
    S_RMW_RD = ST_RMW_RD,
    S_RMW_WR = ST_RMW_WR,
    S_ST     = ST_ST,
    S_ERR    = ST_ERR
  } state_e;

  // Size 3 has no meaning and is folded into the misaligned case.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      SZ_W:    m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends a load value from a memory word,
// and merges sub-word store data into a word read back for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  assign sh      = {addr_i, 3'b000};
  assign shifted = word_i >> sh;

  always_comb begin
    ld_data_o = shifted;
    lane_mask = '1;
    lane_data = wdata_i;
    case (size_i)
      SZ_B: begin
        ld_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << sh;
        lane_data = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        ld_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << {addr_i[1], 4'b0000};
        lane_data = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Replicated store data lets the mask alone pick the destination lanes.
  assign st_word_o = (word_i & ~lane_mask) | (lane_data & lane_mask);

endmodule

// File: rtl/lsu_stage.sv
// Load/store unit FSM: turns byte/half/word requests into word-aligned
// accesses on the memory stage's level req / pulsed fin handshake.
module lsu_stage
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  input  logic        mem_rd_fin,
  input  logic        mem_wr_fin,
  output logic [31:0] mem_rd_addr,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        rd_req_q;
  logic        wr_req_q;
  logic [31:0] wr_data_q;

  logic [31:0] ld_data;
  logic [31:0] st_word;

  lsu_align u_align (
    .word_i     (mem_rd_data),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  assign req_ready   = (state_q == S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign mem_rd_req  = rd_req_q;
  assign mem_wr_req  = wr_req_q;
  assign mem_wr_data = wr_data_q;
  assign mem_rd_addr = {addr_q[31:2], 2'b00};
  assign mem_wr_addr = {addr_q[31:2], 2'b00};

  // Each req drops on the edge its fin is sampled; fins for the other
  // direction are simply not looked at in that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          wdata_q <= req_wdata;
          if (misaligned(req_size, req_addr[1:0])) begin
            state_q <= S_ERR;
          end else if (!req_store) begin
            rd_req_q <= 1'b1;
            state_q  <= S_LD;
          end else if (req_size == SZ_W) begin
            wr_req_q  <= 1'b1;
            wr_data_q <= req_wdata;
            state_q   <= S_ST;
          end else begin
            rd_req_q <= 1'b1;
            state_q  <= S_RMW_RD;
          end
        end
        S_LD: if (mem_rd_fin) begin
          rd_req_q <= 1'b0;
          rdata_q  <= ld_data;
          err_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_RMW_RD: if (mem_rd_fin) begin
          rd_req_q  <= 1'b0;
          wr_req_q  <= 1'b1;
          wr_data_q <= st_word;
          state_q   <= S_RMW_WR;
        end
        S_RMW_WR, S_ST: if (mem_wr_fin) begin
          wr_req_q <= 1'b0;
          err_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_ERR: begin
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed table, randomized traffic against
// a byte-array reference model, and a reset-during-write sequence.
module tb_lsu_stage;

  logic        clk, reset;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        done, err;
  logic [31:0] rdata;
  logic        mem_rd_req, mem_wr_req, mem_rd_fin, mem_wr_fin;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data, mem_rd_data;

  lsu_stage dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_rd_fin(mem_rd_fin), .mem_wr_fin(mem_wr_fin),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:511];     // memory-stage model storage
  logic [7:0]  ref_b [0:2047];  // reference model, byte addressed
  logic [31:0] ref_rdata;
  int          lat;

  int rd_rises = 0, wr_rises = 0, done_cnt = 0, viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory stage: wait lat cycles, pulse fin for one cycle, never re-trigger.
  initial begin
    int  k;
    logic aborted;
    mem_rd_fin = 1'b0;
    mem_wr_fin = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (!reset && (mem_rd_req || mem_wr_req)) begin
        k = 0;
        aborted = 1'b0;
        while (k < lat) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
          k++;
        end
        if (!aborted && !reset && (mem_rd_req || mem_wr_req)) begin
          if (mem_rd_req) begin
            mem_rd_data = mem[mem_rd_addr[10:2]];
            mem_rd_fin = 1'b1;
          end else begin
            mem[mem_wr_addr[10:2]] = mem_wr_data;
            mem_wr_fin = 1'b1;
          end
          @(negedge clk);
          mem_rd_fin = 1'b0;
          mem_wr_fin = 1'b0;
        end
      end
    end
  end

  // Handshake monitor: no overlap, req gone right after its fin edge.
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  always @(posedge clk) begin
    logic frd, fwr;
    frd = mem_rd_fin;
    fwr = mem_wr_fin;
    #1;
    if (reset) begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (mem_rd_req && !prev_rd) rd_rises++;
      if (mem_wr_req && !prev_wr) wr_rises++;
      if (done) done_cnt++;
      if (mem_rd_req && mem_wr_req) viol++;
      if ((frd && mem_rd_req) || (fwr && mem_wr_req)) viol++;
      prev_rd = mem_rd_req;
      prev_wr = mem_wr_req;
    end
  end

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    int idx;
    idx = int'(a[10:2]);
    mem[idx] = w;
    for (int i = 0; i < 4; i++) ref_b[4*idx+i] = w[8*i +: 8];
  endtask

  // Reference: plain byte arithmetic from the access rules.
  task automatic ref_txn(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e_err, output int e_rd, output int e_wr);
    int n, ai;
    longint v, one;
    logic [31:0] tmp;
    one = 1;
    n = 1 << sz;
    ai = int'(a[10:0]);
    if (sz == 2'd3 || (ai % n) != 0) begin
      e_err = 1'b1; e_rd = 0; e_wr = 0;
    end else if (!st) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(ref_b[ai+i]) << (8*i));
      if (!un && n < 4 && v >= (one << (8*n-1))) v = v - (one << (8*n));
      ref_rdata = v[31:0];
      e_err = 1'b0; e_rd = 1; e_wr = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        tmp = wd >> (8*i);
        ref_b[ai+i] = tmp[7:0];
      end
      e_err = 1'b0; e_rd = (n < 4) ? 1 : 0; e_wr = 1;
    end
  endtask

  task automatic do_txn(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int ncyc, output logic ok);
    req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    ncyc = 0;
    ok = 1'b0;
    while (ncyc < 200) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      ncyc++;
    end
  endtask

  task automatic run_check(input string tag, input logic st, input logic [1:0] sz,
                           input logic un, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] e_rdata, input logic e_err,
                           input logic [31:0] e_mem, input int e_rd, input int e_wr);
    int rd0, wr0, dn0, ncyc;
    logic ok;
    rd0 = rd_rises; wr0 = wr_rises; dn0 = done_cnt;
    chk({tag, "_ready"}, req_ready, 1);
    do_txn(st, sz, un, a, wd, ncyc, ok);
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_rdata"}, rdata, e_rdata);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_mem"}, mem[a[10:2]], e_mem);
    chk({tag, "_rd_reqs"}, rd_rises - rd0, e_rd);
    chk({tag, "_wr_reqs"}, wr_rises - wr0, e_wr);
    chk({tag, "_dones"}, done_cnt - dn0, 1);
    if (e_err) chk({tag, "_err_latency"}, ncyc, 1);
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a, wd, pm, e_rdata;
    logic        e_err;
    logic [31:0] e_mem;
    int          e_rd, e_wr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic r_err;
    int   r_rd, r_wr, wcnt;
    logic st, un;
    logic [1:0] sz;
    logic [31:0] a, wd;

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; lat = 0;
    ref_rdata = '0;
    for (int i = 0; i < 512; i++) set_word(32'(i*4), $urandom);

    tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 1'b0, 32'h80FF1234, 1, 0};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80FF1234, 32'h00000080, 1'b0, 32'h80FF1234, 1, 0};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 32'h11223344, 32'h00000080, 1'b0, 32'hBEEF3344, 1, 1};
    tbl[3]  = '{1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, 32'h00000000, 32'h00000080, 1'b0, 32'hCAFEF00D, 0, 1};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h401, 32'h0,        32'h01234567, 32'h00000080, 1'b1, 32'h01234567, 0, 0};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h405, 32'h0,        32'h89ABCDEF, 32'h00000080, 1'b1, 32'h89ABCDEF, 0, 0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h106, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 1'b0, 32'h80FF1234, 1, 0};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h104, 32'h0,        32'h80FF1234, 32'h00001234, 1'b0, 32'h80FF1234, 1, 0};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 32'h501, 32'h123456A5, 32'h11223344, 32'h00001234, 1'b0, 32'h1122A544, 1, 1};
    tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h600, 32'h0,        32'h00000000, 32'h00001234, 1'b1, 32'h00000000, 0, 0};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h700, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1, 0};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h00007777, 32'h80FF1234, 32'hDEADBEEF, 1'b0, 32'h77771234, 1, 1};
    tbl[12] = '{1'b1, 2'd3, 1'b0, 32'h010, 32'h000000FF, 32'hAAAAAAAA, 32'hDEADBEEF, 1'b1, 32'hAAAAAAAA, 0, 0};

    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_req", mem_rd_req, 0);
    chk("rst_wr_req", mem_wr_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back-to-back with alternating 0/5 wait cycles.
    for (int i = 0; i < 13; i++) begin
      lat = (i % 2) ? 5 : 0;
      set_word(tbl[i].a, tbl[i].pm);
      ref_txn(tbl[i].st, tbl[i].sz, tbl[i].un, tbl[i].a, tbl[i].wd, r_err, r_rd, r_wr);
      run_check($sformatf("vec%0d", i), tbl[i].st, tbl[i].sz, tbl[i].un, tbl[i].a,
                tbl[i].wd, tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_mem, tbl[i].e_rd, tbl[i].e_wr);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 2047));
      wd = $urandom;
      lat = $urandom_range(0, 5);
      ref_txn(st, sz, un, a, wd, r_err, r_rd, r_wr);
      run_check($sformatf("rnd%0d", i), st, sz, un, a, wd, ref_rdata, r_err,
                ref_word(int'(a[10:2])), r_rd, r_wr);
    end

    // Reset while the read-modify-write is waiting on its write fin.
    lat = 5;
    req_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h5A; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wcnt = 0;
    while (!mem_wr_req && wcnt < 100) begin @(negedge clk); wcnt++; end
    chk("rstmid_reached_wr", mem_wr_req, 1);
    reset = 1'b1;
    #1;
    chk("rstmid_done", done, 0);
    chk("rstmid_err", err, 0);
    chk("rstmid_rd_req", mem_rd_req, 0);
    chk("rstmid_wr_req", mem_wr_req, 0);
    chk("rstmid_rdata", rdata, 0);
    chk("rstmid_wr_data", mem_wr_data, 0);
    chk("rstmid_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ref_rdata = '0;
    @(negedge clk);
    lat = 2;
    ref_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r_err, r_rd, r_wr);
    run_check("post_rst_ld", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, ref_rdata, r_err,
              ref_word(4), r_rd, r_wr);

    repeat (3) @(negedge clk);
    chk("handshake_violations", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
